// File: rtl/reg128_seq_pkg.sv
// reg128_seq_pkg: FSM states, word count and 128-bit word mapping for reg128_seq
package reg128_seq_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_e;

   localparam int NWORDS = 4;

   // word k occupies bits [127-32k : 96-32k], so its lsb is (3-k)*32
   function automatic logic [6:0] word_lsb(input logic [1:0] k);
      return {~k, 5'b0};
   endfunction

   function automatic logic [31:0] word_slice(input logic [127:0] v, input logic [1:0] k);
      return v[word_lsb(k) +: 32];
   endfunction

endpackage

// File: rtl/reg128_seq_arb.sv
// reg128_seq_arb: 2-way round-robin arbiter
//   req_i     : request per requester
//   load_i    : commit the current grant (updates rr_last)
//   gnt_o     : one-hot candidate grant; on a tie the requester != rr_last wins
//   rr_last_o : index of the most recently granted requester (resets to 1)
module reg128_seq_arb (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [1:0] req_i,
   input  logic       load_i,
   output logic [1:0] gnt_o,
   output logic       rr_last_o
);

   logic rr_last_q, rr_last_d;

   always_comb begin
      gnt_o     = (&req_i) ? (rr_last_q ? 2'b01 : 2'b10) : req_i;
      rr_last_d = (load_i && |gnt_o) ? gnt_o[1] : rr_last_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) rr_last_q <= 1'b1;
      else          rr_last_q <= rr_last_d;

   assign rr_last_o = rr_last_q;

endmodule

// File: rtl/reg128_seq.sv
// reg128_seq: Wishbone pipelined master doing atomic 128-bit accesses as four 32-bit words
//   req_i/we_i/wdata_i : two local requesters (requester n uses wdata_i[128n+127:128n])
//   gnt_o/done_o/err_o : grant while on the bus, one-cycle completion pulse, failure flag
//   rdata_o            : last successfully read 128-bit value
//   wb_*               : Wishbone master port, word address on wb_adr_o, MS word first
//   Optional macro REG128_SEQ_TIMEOUT_EN: per-word ack timeout of TIMEOUT_CYCLES cycles.
module reg128_seq
   import reg128_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [1:0]   req_i,
   input  logic [1:0]   we_i,
   input  logic [255:0] wdata_i,
   output logic [1:0]   gnt_o,
   output logic [1:0]   done_o,
   output logic         err_o,
   output logic [127:0] rdata_o,
   output logic         wb_cyc_o,
   output logic         wb_stb_o,
   output logic [1:0]   wb_adr_o,
   output logic [3:0]   wb_sel_o,
   output logic         wb_we_o,
   output logic [31:0]  wb_dat_o,
   input  logic [31:0]  wb_dat_i,
   input  logic         wb_ack_i,
   input  logic         wb_err_i,
   input  logic         wb_stall_i
);

   state_e       state_q, state_d;
   logic [1:0]   word_q, word_d;
   logic         we_q, we_d, err_q, err_d;
   logic [127:0] wr_q, wr_d, rd_q, rd_d, rdata_q, rdata_d;
   logic [1:0]   arb_gnt, cur;
   logic         rr_last, load, tmo;

   reg128_seq_arb u_arb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .req_i     (req_i),
      .load_i    (load),
      .gnt_o     (arb_gnt),
      .rr_last_o (rr_last)
   );

   // rr_last holds the served requester from grant until the next grant
   assign cur = {rr_last, ~rr_last};

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      we_d    = we_q;
      err_d   = err_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;
      load    = 1'b0;
      case (state_q)
         IDLE: if (|arb_gnt) begin
            load    = 1'b1;
            we_d    = arb_gnt[1] ? we_i[1] : we_i[0];
            wr_d    = arb_gnt[1] ? wdata_i[255:128] : wdata_i[127:0];
            word_d  = 2'd0;
            err_d   = 1'b0;
            state_d = ADDR;
         end
         ADDR: begin
            if (tmo) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (!wb_stall_i) state_d = WAIT;
         end
         WAIT: begin
            if (wb_err_i || tmo) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (wb_ack_i) begin
               if (!we_q) rd_d[word_lsb(word_q) +: 32] = wb_dat_i;
               word_d  = word_q + 2'd1;
               state_d = (word_q == 2'(NWORDS - 1)) ? DONE : ADDR;
            end
         end
         default: begin
            if (!err_q && !we_q) rdata_d = rd_q;
            state_d = IDLE;
         end
      endcase
   end

`ifdef REG128_SEQ_TIMEOUT_EN
   localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW     = CW_RAW < 8 ? 8 : (CW_RAW > 16 ? 16 : CW_RAW);

   logic [CW-1:0] cnt_q, cnt_d;

   // counts ADDR+WAIT cycles of the current word; restarts when the next word is issued
   always_comb cnt_d = (wb_cyc_o && !(state_q == WAIT && state_d == ADDR)) ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;

   assign tmo = wb_cyc_o && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   // no timeout: wait for ack or err indefinitely (parameter only matters with the macro)
   assign tmo = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state_q <= IDLE;
         word_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         we_q    <= we_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
      end

   assign wb_cyc_o = (state_q == ADDR) || (state_q == WAIT);
   assign wb_stb_o = (state_q == ADDR);
   assign wb_adr_o = wb_cyc_o ? word_q : 2'd0;
   assign wb_sel_o = {4{wb_cyc_o}};
   assign wb_we_o  = wb_cyc_o && we_q;
   assign wb_dat_o = wb_we_o ? word_slice(wr_q, word_q) : 32'd0;
   assign gnt_o    = wb_cyc_o ? cur : 2'b00;
   assign done_o   = (state_q == DONE) ? cur : 2'b00;
   assign err_o    = (state_q == DONE) && err_q;
   // a successful read is visible in its DONE cycle
   assign rdata_o  = rdata_d;

endmodule

// File: tb/tb_reg128_seq.sv
// tb_reg128_seq: table-driven, random and corner-case checks of reg128_seq against a slave memory model
module tb_reg128_seq;

   logic         clk_i = 1'b0;
   logic         rst_n_i = 1'b1;
   logic [1:0]   req_i = '0;
   logic [1:0]   we_i = '0;
   logic [255:0] wdata_i = '0;
   logic [1:0]   gnt_o, done_o;
   logic         err_o;
   logic [127:0] rdata_o;
   logic         wb_cyc_o, wb_stb_o, wb_we_o;
   logic [1:0]   wb_adr_o;
   logic [3:0]   wb_sel_o;
   logic [31:0]  wb_dat_o;
   logic [31:0]  wb_dat_i = '0;
   logic         wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

   reg128_seq #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i), .wdata_i(wdata_i),
      .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // slave model: 4-word register, optional stall/error injection, or silent (mute)
   logic [31:0] mem [4];
   int          stall_word = -1, stall_left = 0, err_word = -1;
   bit          mute = 1'b0;
   logic [1:0]  log_adr [$];
   logic [31:0] log_dat [$];
   logic        log_we [$];
   logic [127:0] rdata_exp = '0;

   initial begin
      bit         acc;
      logic [1:0] a;
      forever begin
         @(negedge clk_i);
         acc = rst_n_i && wb_stb_o && !wb_stall_i;
         a   = wb_adr_o;
         if (acc) begin
            log_adr.push_back(a);
            log_dat.push_back(wb_dat_o);
            log_we.push_back(wb_we_o);
            if (wb_we_o && !mute && int'(a) != err_word) mem[a] = wb_dat_o;
         end
         @(posedge clk_i);
         #1;
         wb_ack_i   = acc && !mute && int'(a) != err_word;
         wb_err_i   = acc && !mute && int'(a) == err_word;
         wb_dat_i   = mem[a];
         wb_stall_i = wb_stb_o && int'(wb_adr_o) == stall_word && stall_left > 0;
         if (wb_stall_i) stall_left--;
      end
   end

   task automatic run_txn(input int r, input bit we, input logic [127:0] d, input int sw, input int sn,
                          input int ew, input int exp_n, input int exp_lat, input bit exp_err);
      int           n, held;
      bit           seen, cyc_bad, early, sel_bad, word_bad, hmove;
      logic [31:0]  hdat;
      logic [127:0] prev, exp_rd;
      exp_rd = {mem[0], mem[1], mem[2], mem[3]};
      prev = rdata_exp;
      stall_word = sw; stall_left = sn; err_word = ew;
      log_adr.delete(); log_dat.delete(); log_we.delete();
      @(negedge clk_i);
      req_i[r] = 1'b1; we_i[r] = we; wdata_i[128*r +: 128] = d;
      n = 1; held = 0; seen = 0; cyc_bad = 0; early = 0; sel_bad = 0; hmove = 0; hdat = '0;
      while (!seen && n < 400) begin
         @(negedge clk_i);
         n++;
         if (done_o != 2'b00) seen = 1;
         else begin
            if (!wb_cyc_o) cyc_bad = 1;
            if (rdata_o !== prev) early = 1;
            if (wb_stb_o) begin
               if (wb_sel_o != 4'hF) sel_bad = 1;
               if (int'(wb_adr_o) == sw) begin
                  if (held == 0) hdat = wb_dat_o;
                  else if (wb_dat_o !== hdat) hmove = 1;
                  held++;
               end
            end
         end
      end
      req_i[r] = 1'b0;
      check("done_seen", 128'(seen), 1);
      check("latency", 128'(n), 128'(exp_lat));
      check("done_vec", done_o, 128'(1 << r));
      check("err", err_o, exp_err);
      check("cyc_at_done", wb_cyc_o, 0);
      check("cyc_continuous", cyc_bad, 0);
      check("rdata_early", early, 0);
      check("sel", sel_bad, 0);
      if (!we && !exp_err) rdata_exp = exp_rd;
      check("rdata_done", rdata_o, rdata_exp);
      check("n_strobes", 128'(log_adr.size()), 128'(exp_n));
      word_bad = 0;
      foreach (log_adr[k])
         if (int'(log_adr[k]) != k || log_we[k] != we || (we && log_dat[k] !== 32'(d >> (96 - 32*k))))
            word_bad = 1;
      check("words", word_bad, 0);
      if (sn > 0) begin
         check("stall_held_cycles", 128'(held), 128'(sn + 1));
         check("stall_dat_stable", hmove, 0);
      end
      @(negedge clk_i);
      check("done_one_cycle", done_o, 0);
   endtask

   typedef struct {
      int r; bit we; logic [127:0] d; bit load; logic [127:0] pre; bit mute;
      int sw, sn, ew, exp_n, exp_lat; bit exp_err;
   } vec_t;
   vec_t v [$];

   initial begin
      bit flag;
      int n, idx, last;
      int order [$];
      #1 rst_n_i = 1'b0;
      #1;
      check("reset_ctl", {gnt_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o}, 0);
      check("reset_rdata", rdata_o, 0);
      for (int k = 0; k < 4; k++) mem[k] = '0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;

      v.push_back('{0, 1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 0, 0, -1, 0, -1, 4, 10, 0});
      v.push_back('{1, 0, 0, 1, 128'hA0000000_B0000001_C0000002_D0000003, 0, -1, 0, -1, 4, 10, 0});
      v.push_back('{0, 1, 128'h11111111_22222222_33333333_44444444, 0, 0, 0, 1, 3, -1, 4, 13, 0});
      v.push_back('{1, 0, 0, 1, 128'h55555555_66666666_77777777_88888888, 0, -1, 0, 2, 3, 8, 1});
      v.push_back('{0, 0, 0, 0, 0, 0, -1, 0, -1, 4, 10, 0});
      v.push_back('{1, 1, 128'hDEADBEEF_CAFEF00D_0BADF00D_FEEDFACE, 0, 0, 0, -1, 0, 1, 2, 6, 1});
      v.push_back('{0, 0, 0, 0, 0, 0, -1, 0, -1, 4, 10, 0});
`ifdef REG128_SEQ_TIMEOUT_EN
      v.push_back('{0, 0, 0, 0, 0, 1, -1, 0, -1, 1, 18, 1});
`endif
      foreach (v[i]) begin
         if (v[i].load) for (int k = 0; k < 4; k++) mem[k] = 32'(v[i].pre >> (96 - 32*k));
         mute = v[i].mute;
         run_txn(v[i].r, v[i].we, v[i].d, v[i].sw, v[i].sn, v[i].ew, v[i].exp_n, v[i].exp_lat, v[i].exp_err);
         mute = 1'b0;
      end

      for (int i = 0; i < 16; i++) begin
         int sn;
         sn = $urandom_range(0, 2);
         run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3), sn, -1, 4, 10 + sn, 0);
      end

      // reset while waiting for an ack
      stall_word = -1; stall_left = 0; err_word = -1;
      @(negedge clk_i);
      req_i[1] = 1'b1; we_i[1] = 1'b0;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!(wb_cyc_o && !wb_stb_o) && n < 50);
      check("reach_wait", 128'(wb_cyc_o && !wb_stb_o), 1);
      #2 rst_n_i = 1'b0;
      #1;
      check("async_reset_ctl", {gnt_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o}, 0);
      check("async_reset_rdata", rdata_o, 0);
      req_i = '0;
      rdata_exp = '0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      flag = 0;
      repeat (15) begin @(negedge clk_i); if (done_o != 2'b00) flag = 1; end
      check("no_done_after_reset", flag, 0);

      // round robin: both request together and re-request after each completion
      @(negedge clk_i);
      req_i = 2'b11; we_i = 2'b00;
      last = -1; n = 0;
      while (order.size() < 4 && n < 200) begin
         @(negedge clk_i);
         n++;
         if (last >= 0) begin req_i[last] = 1'b1; last = -1; end
         if (done_o != 2'b00) begin
            idx = int'(done_o[1]);
            order.push_back(idx);
            req_i[idx] = 1'b0;
            last = idx;
         end
      end
      req_i = '0;
      check("rr_count", 128'(order.size()), 4);
      foreach (order[k]) check($sformatf("rr_grant_%0d", k), 128'(order[k]), 128'(k % 2));
      repeat (12) @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/reg128_seq.md
Name: reg128_seq

Overview:
- Wishbone pipelined master that performs atomic 128-bit reads and writes of a wide register on a 32-bit register bank.
- Each wide access runs as four sequential 32-bit word accesses.
- Two local requesters share the bus port through round-robin arbitration.
- Sits between control logic (e.g. a timestamp or config loader) and the CSR slave holding the 128-bit register.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting for ack per word; used only when REG128_SEQ_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_i  in  2  request per requester; held high until matching done_o
- we_i  in  2  1=write, 0=read; sampled at grant
- wdata_i  in  256  write data; requester n uses [128n+127:128n]
- gnt_o  out  2  one-hot; requester currently being served
- done_o  out  2  one-cycle completion pulse per requester
- err_o  out  1  valid with done_o; 1=access failed
- rdata_o  out  128  last successfully read 128-bit value
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_adr_o  out  2  word address [3:2]
- wb_sel_o  out  4  always 4'hF
- wb_we_o  out  1  write enable
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  ack
- wb_err_i  in  1  error
- wb_stall_i  in  1  stall

Behaviour:
- Reset is asynchronous, active-low. All outputs reset to 0. The FSM resets to IDLE. rr_last resets to 1, so requester 0 wins the first tie.
- Word mapping: word address k carries bits [127-32k : 96-32k]. Words are issued in order k=0,1,2,3, most-significant word first.
- FSM states:
  - IDLE: on any req_i bit, grant it. If both are set, grant the requester != rr_last. Set rr_last to the granted index. Latch we_i and the selected wdata_i into a 128-bit shadow. Clear word to 0. Go to ADDR.
  - ADDR: drive cyc=1, stb=1, adr=word, we, dat=shadow word. When wb_stall_i=0 the strobe is accepted; go to WAIT. Hold all outputs stable while stalled.
  - WAIT: drive cyc=1, stb=0.
    - On wb_err_i: go to DONE with err.
    - On wb_ack_i: for a read, store wb_dat_i into the read shadow slot for word. Then, if word==3, go to DONE; otherwise increment word and go to ADDR next cycle.
    - ack and err together count as err.
  - DONE: cyc=0. Pulse done_o[gnt]=1 with err_o. On a successful read, rdata_o takes the read shadow in this same cycle. Clear gnt_o. Go to IDLE.
- Only one outstanding bus access at a time. wb_cyc_o stays high from the first ADDR to the last WAIT; the lock prevents tearing.
- An ack or err arriving while in IDLE, ADDR or DONE is ignored.
- Error: the remaining words are not issued. A partial write stays in the slave. rdata_o is unchanged.
- A requester that drops req_i mid-transaction does not abort it; done_o still pulses.
- The requester must not re-raise req_i in the cycle of its done_o. The arbiter samples req_i only in IDLE, so the earliest re-grant is the cycle after DONE.
- Minimum latency, with stall=0 and ack the cycle after the strobe: grant to done is 1 + 4×2 + 1 = 10 cycles.
- Reset mid-operation: cyc and stb drop immediately. No done_o pulse is produced.

Optional Feature:
- Macro REG128_SEQ_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter, sized from TIMEOUT_CYCLES, counts cycles spent in ADDR+WAIT for the current word. It restarts on every word.
  - Reaching TIMEOUT_CYCLES acts as wb_err_i: abort, then DONE with err_o=1.
- Not defined: no counter; the block waits indefinitely for ack or err.

Decomposition:
- Package reg128_seq_pkg holds:
  - the FSM state enum (IDLE, ADDR, WAIT, DONE);
  - NWORDS=4;
  - the word-slice function mapping k to the bit range.
- One sub-module: reg128_seq_arb, a 2-way round-robin arbiter with inputs req[1:0] and load, and outputs gnt one-hot and rr_last.
- The FSM and datapath stay in the top level.

Test Plan:
- Write by requester 0 of 0x00112233_44556677_8899AABB_CCDDEEFF; slave has stall=0 and ack after 1 cycle. Required: words written to adr 0..3 as 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; sel=F throughout; done_o=01 with err_o=0 at cycle 10; cyc high continuously.
- Read by requester 1; slave returns 0xA0000000, 0xB0000001, 0xC0000002, 0xD0000003. Required: rdata_o=0xA0000000_B0000001_C0000002_D0000003 in the done_o=10 cycle and not earlier.
- Both requesters assert in the same cycle, then keep re-requesting. Required: grants alternate 0,1,0,1; after reset the first grant goes to 0.
- Slave stalls 3 cycles on word 1. Required: adr=1 and dat held stable for 4 cycles with stb=1; total latency 13 cycles.
- Slave asserts wb_err_i on word 2 of a read. Required: no strobe for word 3; done_o with err_o=1; rdata_o keeps its previous value.
- With REG128_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, the slave never acks word 0. Required: err_o=1 after 16 cycles; cyc drops. Additionally, rst_n_i asserted mid-WAIT forces all outputs to 0 asynchronously.
